// File: rtl/ins_cache_dm.sv
// Direct-mapped instruction cache between the program counter and AP_ctrl.
// Each line holds LINE_WORDS instructions and has its own tag and valid bit.
// A miss refills the whole line with one burst from the DDR interface.
// The response is a registered one-cycle pulse on the edge that leaves RESP.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a fetch; do the tag lookup and the range check
// REQ   | hold the burst request until the DDR side acknowledges it
// FILL  | write the incoming beats into the line, capture the requested word
// RESP  | drive the one-cycle response pulse, then return to IDLE
module ins_cache_dm #(
  parameter int ISA_WIDTH       = 30,
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int LINE_WORDS      = 16,
  parameter int NUM_LINES       = 8,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int DDR_STRIDE      = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_req,
  input  logic [ADDR_WIDTH_MEM-1:0] fetch_addr,
  output logic                      fetch_ready,
  output logic [ISA_WIDTH-1:0]      instruction,
  output logic                      ins_valid,
  output logic                      ins_err,
  input  logic                      flush,
  output logic                      ISA_read_req,
  input  logic                      ISA_read_ack,
  output logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
  output logic [9:0]                isa_read_len,
  input  logic [ISA_WIDTH-1:0]      instruction_to_cache,
  input  logic                      rd_burst_data_valid,
  output logic [CNT_WIDTH-1:0]      hit_cnt,
  output logic [CNT_WIDTH-1:0]      miss_cnt,
  output logic [1:0]                st_cur_ins_cache
);

  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int TAG_W    = ADDR_WIDTH_MEM - OFF_W - IDX_BITS;
  localparam logic [ADDR_WIDTH_MEM-1:0] OFF_MASK = ADDR_WIDTH_MEM'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_WIDTH_MEM-1:0] a);
    return OFF_W'(a);
  endfunction

  // With a single line there are no index bits; every address uses line 0.
  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH_MEM-1:0] a);
    if (IDX_BITS == 0) return '0;
    return IDX_W'(a >> OFF_W);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_WIDTH_MEM-1:0] a);
    return TAG_W'(a >> (OFF_W + IDX_BITS));
  endfunction

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH_MEM-1:0] addr_q, addr_d;
  logic [9:0]                len_q, len_d;
  logic [9:0]                beat_q, beat_d;
  logic                      flush_seen_q, flush_seen_d;
  logic [ISA_WIDTH-1:0]      resp_data_q, resp_data_d;
  logic                      resp_err_q, resp_err_d;
  logic [ISA_WIDTH-1:0]      instr_q, instr_d;
  logic                      ins_valid_q, ins_valid_d;
  logic                      ins_err_q, ins_err_d;
  logic [CNT_WIDTH-1:0]      hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]      miss_cnt_q, miss_cnt_d;
  logic [NUM_LINES-1:0]      valid_q, valid_d;

  logic [ISA_WIDTH-1:0]      mem_q [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]          tag_q [NUM_LINES];
  logic                      mem_we;
  logic                      tag_we;

  logic [IDX_W-1:0]          in_idx;
  logic [OFF_W-1:0]          in_off;
  logic [ADDR_WIDTH_MEM-1:0] in_base;
  logic [31:0]               in_rem;
  logic [9:0]                in_len;
  logic                      in_range;
  logic                      in_hit;
  logic [IDX_W-1:0]          cur_idx;
  logic [ADDR_WIDTH_MEM-1:0] cur_base;

  assign in_idx   = idx_of(fetch_addr);
  assign in_off   = off_of(fetch_addr);
  assign in_base  = fetch_addr & ~OFF_MASK;
  assign in_range = 32'(fetch_addr) < 32'(TOTAL_ISA_DEPTH);
  // Only meaningful for in-range addresses, where the base is below the depth.
  assign in_rem   = 32'(TOTAL_ISA_DEPTH) - 32'(in_base);
  assign in_len   = (in_rem < 32'(LINE_WORDS)) ? in_rem[9:0] : 10'(LINE_WORDS);
  assign in_hit   = valid_q[in_idx] && (tag_q[in_idx] == tag_of(fetch_addr));
  assign cur_idx  = idx_of(addr_q);
  assign cur_base = addr_q & ~OFF_MASK;

  // Next-state, counter and response logic for the lookup/refill sequence.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_d       = beat_q;
    flush_seen_d = flush_seen_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    instr_d      = instr_q;
    ins_valid_d  = 1'b0;
    ins_err_d    = 1'b0;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    valid_d      = valid_q;
    mem_we       = 1'b0;
    tag_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          addr_d = fetch_addr;
          if (!in_range) begin
            resp_data_d = '0;
            resp_err_d  = 1'b1;
            state_d     = RESP;
          end else if (in_hit && !flush) begin
            resp_data_d = mem_q[in_idx][in_off];
            resp_err_d  = 1'b0;
            if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
            state_d     = RESP;
          end else begin
            // A flush arriving with the request has already been applied, so
            // the refilled line may become valid.
            if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
            len_d        = in_len;
            beat_d       = '0;
            flush_seen_d = 1'b0;
            state_d      = REQ;
          end
        end
      end
      REQ: begin
        if (flush) flush_seen_d = 1'b1;
        if (ISA_read_ack) state_d = FILL;
      end
      FILL: begin
        if (flush) flush_seen_d = 1'b1;
        if (rd_burst_data_valid && (beat_q < len_q)) begin
          mem_we = 1'b1;
          beat_d = beat_q + 10'd1;
          if (beat_q == 10'(off_of(addr_q))) resp_data_d = instruction_to_cache;
          if (beat_q == len_q - 10'd1) begin
            tag_we     = 1'b1;
            resp_err_d = 1'b0;
            if (!flush_seen_q && !flush) valid_d[cur_idx] = 1'b1;
            state_d    = RESP;
          end
        end
      end
      RESP: begin
        instr_d     = resp_data_q;
        ins_err_d   = resp_err_q;
        ins_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) valid_d = '0;
  end

  // Control state, counters and valid bits; reset aborts any refill in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      flush_seen_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      instr_q      <= '0;
      ins_valid_q  <= 1'b0;
      ins_err_q    <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      flush_seen_q <= flush_seen_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      instr_q      <= instr_d;
      ins_valid_q  <= ins_valid_d;
      ins_err_q    <= ins_err_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      valid_q      <= valid_d;
    end
  end

  // Line data and tags need no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cur_idx][beat_q[OFF_W-1:0]] <= instruction_to_cache;
    if (tag_we) tag_q[cur_idx] <= tag_of(addr_q);
  end

  assign fetch_ready      = (state_q == IDLE);
  assign ISA_read_req     = (state_q == REQ);
  assign ISA_read_addr    = (state_q == REQ) ?
                            DDR_ADDR_WIDTH'(32'(cur_base) * 32'(DDR_STRIDE)) : '0;
  assign isa_read_len     = (state_q == REQ) ? len_q : '0;
  assign instruction      = instr_q;
  assign ins_valid        = ins_valid_q;
  assign ins_err          = ins_err_q;
  assign hit_cnt          = hit_cnt_q;
  assign miss_cnt         = miss_cnt_q;
  assign st_cur_ins_cache = state_q;

endmodule

// File: tb/tb_ins_cache_dm.sv
// Bench for ins_cache_dm: two instances (depth 128 and depth 256), each with
// its own DDR burst responder returning data = instruction address + 0x100.
module tb_ins_cache_dm;

  logic        clk;
  logic        rst;
  logic        req        [2];
  logic [15:0] faddr      [2];
  logic        ready      [2];
  logic [29:0] ins        [2];
  logic        ivalid     [2];
  logic        ierr       [2];
  logic        flush      [2];
  logic        rd_req     [2];
  logic        ack        [2];
  logic [27:0] rd_addr    [2];
  logic [9:0]  rd_len     [2];
  logic [29:0] bdata      [2];
  logic        bvalid     [2];
  logic [15:0] hitc       [2];
  logic [15:0] missc      [2];
  logic [1:0]  st         [2];

  int          ack_lat    [2];
  int          bursts     [2];
  int          beats_sent [2];
  logic [27:0] last_raddr [2];
  logic [9:0]  last_rlen  [2];

  int checks;
  int errors;

  typedef struct {
    int          d;
    logic [15:0] a;
    logic        miss;
    logic [29:0] ins;
    logic        err;
    logic [27:0] raddr;
    logic [9:0]  rlen;
    logic [15:0] hits;
    logic [15:0] misses;
  } vec_t;

  vec_t vecs[$];

  ins_cache_dm u_dut0 (
    .clk(clk), .rst(rst),
    .fetch_req(req[0]), .fetch_addr(faddr[0]), .fetch_ready(ready[0]),
    .instruction(ins[0]), .ins_valid(ivalid[0]), .ins_err(ierr[0]),
    .flush(flush[0]),
    .ISA_read_req(rd_req[0]), .ISA_read_ack(ack[0]),
    .ISA_read_addr(rd_addr[0]), .isa_read_len(rd_len[0]),
    .instruction_to_cache(bdata[0]), .rd_burst_data_valid(bvalid[0]),
    .hit_cnt(hitc[0]), .miss_cnt(missc[0]), .st_cur_ins_cache(st[0])
  );

  ins_cache_dm #(.TOTAL_ISA_DEPTH(256)) u_dut1 (
    .clk(clk), .rst(rst),
    .fetch_req(req[1]), .fetch_addr(faddr[1]), .fetch_ready(ready[1]),
    .instruction(ins[1]), .ins_valid(ivalid[1]), .ins_err(ierr[1]),
    .flush(flush[1]),
    .ISA_read_req(rd_req[1]), .ISA_read_ack(ack[1]),
    .ISA_read_addr(rd_addr[1]), .isa_read_len(rd_len[1]),
    .instruction_to_cache(bdata[1]), .rd_burst_data_valid(bvalid[1]),
    .hit_cnt(hitc[1]), .miss_cnt(missc[1]), .st_cur_ins_cache(st[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // DDR side: ack after ack_lat cycles, then one beat per cycle.
  task automatic ddr_serve(input int d);
    forever begin
      @(negedge clk);
      if (rst && rd_req[d]) begin
        bursts[d]++;
        beats_sent[d] = 0;
        last_raddr[d] = rd_addr[d];
        last_rlen[d]  = rd_len[d];
        for (int w = 0; w < ack_lat[d] && rst; w++) @(negedge clk);
        if (rst) begin
          ack[d] = 1'b1;
          @(negedge clk);
          ack[d] = 1'b0;
          for (int b = 0; b < int'(last_rlen[d]) && rst; b++) begin
            bvalid[d] = 1'b1;
            bdata[d]  = 30'(int'(last_raddr[d]) / 8 + b + 256);
            @(negedge clk);
            beats_sent[d] = b + 1;
          end
          bvalid[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic start_fetch(input int d, input logic [15:0] a, input logic with_flush);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready[d] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_fetch", 64'(ready[d]), 64'd1);
    req[d]   = 1'b1;
    faddr[d] = a;
    flush[d] = with_flush;
    @(posedge clk);
    #1;
    req[d]   = 1'b0;
    flush[d] = 1'b0;
  endtask

  // lat counts clock edges with the accepting edge as 1.
  task automatic wait_resp(input int d, output logic [29:0] o_ins, output logic o_err,
                           output int lat);
    lat   = 1;
    o_ins = '0;
    o_err = 1'b0;
    while (lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (ivalid[d]) begin
        o_ins = ins[d];
        o_err = ierr[d];
        break;
      end
    end
    chk("resp_seen", 64'(ivalid[d]), 64'd1);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", 64'(ivalid[d]), 64'd0);
  endtask

  task automatic wait_burst_beats(input int d, input int b0, input int nbeats);
    int guard;
    guard = 0;
    while (bursts[d] == b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    while (beats_sent[d] < nbeats && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk("burst_progress", 64'(beats_sent[d]), 64'(nbeats));
  endtask

  function automatic vec_t mk(input int d, input int a, input logic miss, input int i,
                              input logic err, input int raddr, input int rlen,
                              input int hits, input int misses);
    vec_t v;
    v.d = d; v.a = 16'(a); v.miss = miss; v.ins = 30'(i); v.err = err;
    v.raddr = 28'(raddr); v.rlen = 10'(rlen);
    v.hits = 16'(hits); v.misses = 16'(misses);
    return v;
  endfunction

  initial begin
    logic [29:0] r_ins;
    logic        r_err;
    int          lat;
    int          b0;
    int          exp_lat;

    checks = 0;
    errors = 0;
    rst    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; faddr[d] = '0; flush[d] = 1'b0;
      ack[d] = 1'b0; bvalid[d] = 1'b0; bdata[d] = '0;
      bursts[d] = 0; beats_sent[d] = 0;
      last_raddr[d] = '0; last_rlen[d] = '0;
    end
    ack_lat[0] = 2;
    ack_lat[1] = 0;
    fork
      ddr_serve(0);
      ddr_serve(1);
    join_none

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 64'(ready[d]), 64'd1);
      chk("rst_valid", 64'(ivalid[d]), 64'd0);
      chk("rst_err", 64'(ierr[d]), 64'd0);
      chk("rst_ins", 64'(ins[d]), 64'd0);
      chk("rst_rdreq", 64'(rd_req[d]), 64'd0);
      chk("rst_hit", 64'(hitc[d]), 64'd0);
      chk("rst_miss", 64'(missc[d]), 64'd0);
      chk("rst_state", 64'(st[d]), 64'd0);
    end
    rst = 1'b1;

    // Instance 0 (depth 128): cold line, hits, last line, range edges.
    vecs.push_back(mk(0, 0, 1'b1, 'h100, 1'b0, 0, 16, 0, 1));
    for (int a = 1; a < 16; a++) vecs.push_back(mk(0, a, 1'b0, 'h100 + a, 1'b0, 0, 0, a, 1));
    vecs.push_back(mk(0, 120, 1'b1, 'h178, 1'b0, 896, 16, 15, 2));
    vecs.push_back(mk(0, 130, 1'b0, 0, 1'b1, 0, 0, 15, 2));
    vecs.push_back(mk(0, 127, 1'b0, 'h17F, 1'b0, 0, 0, 16, 2));
    vecs.push_back(mk(0, 128, 1'b0, 0, 1'b1, 0, 0, 16, 2));
    // Instance 1 (depth 256): 0 and 128 share line 0.
    vecs.push_back(mk(1, 0, 1'b1, 'h100, 1'b0, 0, 16, 0, 1));
    vecs.push_back(mk(1, 128, 1'b1, 'h180, 1'b0, 1024, 16, 0, 2));
    vecs.push_back(mk(1, 0, 1'b1, 'h100, 1'b0, 0, 16, 0, 3));
    vecs.push_back(mk(1, 5, 1'b0, 'h105, 1'b0, 0, 0, 1, 3));

    foreach (vecs[k]) begin
      b0 = bursts[vecs[k].d];
      start_fetch(vecs[k].d, vecs[k].a, 1'b0);
      wait_resp(vecs[k].d, r_ins, r_err, lat);
      exp_lat = vecs[k].miss ? ack_lat[vecs[k].d] + int'(vecs[k].rlen) + 3 : 2;
      chk($sformatf("v%0d_ins", k), 64'(r_ins), 64'(vecs[k].ins));
      chk($sformatf("v%0d_err", k), 64'(r_err), 64'(vecs[k].err));
      chk($sformatf("v%0d_lat", k), 64'(lat), 64'(exp_lat));
      chk($sformatf("v%0d_bursts", k), 64'(bursts[vecs[k].d] - b0), 64'(vecs[k].miss));
      if (vecs[k].miss) begin
        chk($sformatf("v%0d_raddr", k), 64'(last_raddr[vecs[k].d]), 64'(vecs[k].raddr));
        chk($sformatf("v%0d_rlen", k), 64'(last_rlen[vecs[k].d]), 64'(vecs[k].rlen));
      end
      chk($sformatf("v%0d_hitcnt", k), 64'(hitc[vecs[k].d]), 64'(vecs[k].hits));
      chk($sformatf("v%0d_misscnt", k), 64'(missc[vecs[k].d]), 64'(vecs[k].misses));
    end

    // Flush in the middle of refilling line 32: response still delivered,
    // but the line stays invalid so 33 misses; after that 34 hits.
    b0 = bursts[0];
    start_fetch(0, 16'd32, 1'b0);
    wait_burst_beats(0, b0, 3);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    wait_resp(0, r_ins, r_err, lat);
    chk("flushfill_ins", 64'(r_ins), 64'h120);
    chk("flushfill_miss", 64'(missc[0]), 64'd3);
    b0 = bursts[0];
    start_fetch(0, 16'd33, 1'b0);
    wait_resp(0, r_ins, r_err, lat);
    chk("refetch33_burst", 64'(bursts[0] - b0), 64'd1);
    chk("refetch33_ins", 64'(r_ins), 64'h121);
    chk("refetch33_miss", 64'(missc[0]), 64'd4);
    b0 = bursts[0];
    start_fetch(0, 16'd34, 1'b0);
    wait_resp(0, r_ins, r_err, lat);
    chk("fetch34_burst", 64'(bursts[0] - b0), 64'd0);
    chk("fetch34_ins", 64'(r_ins), 64'h122);
    chk("fetch34_hit", 64'(hitc[0]), 64'd17);

    // Flush together with a fetch in IDLE: treated as a miss, line then valid.
    b0 = bursts[1];
    start_fetch(1, 16'd5, 1'b1);
    wait_resp(1, r_ins, r_err, lat);
    chk("idleflush_burst", 64'(bursts[1] - b0), 64'd1);
    chk("idleflush_ins", 64'(r_ins), 64'h105);
    chk("idleflush_miss", 64'(missc[1]), 64'd4);
    b0 = bursts[1];
    start_fetch(1, 16'd6, 1'b0);
    wait_resp(1, r_ins, r_err, lat);
    chk("after_flush_hit_burst", 64'(bursts[1] - b0), 64'd0);
    chk("after_flush_hit_ins", 64'(r_ins), 64'h106);
    chk("after_flush_hit_cnt", 64'(hitc[1]), 64'd2);

    // Reset during refill at beat 5: asynchronous abort.
    b0 = bursts[0];
    start_fetch(0, 16'd64, 1'b0);
    wait_burst_beats(0, b0, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rdreq", 64'(rd_req[0]), 64'd0);
    chk("midrst_state", 64'(st[0]), 64'd0);
    chk("midrst_ready", 64'(ready[0]), 64'd1);
    chk("midrst_miss", 64'(missc[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    b0 = bursts[0];
    start_fetch(0, 16'd64, 1'b0);
    wait_resp(0, r_ins, r_err, lat);
    chk("postrst64_burst", 64'(bursts[0] - b0), 64'd1);
    chk("postrst64_ins", 64'(r_ins), 64'h140);
    chk("postrst64_miss", 64'(missc[0]), 64'd1);
    b0 = bursts[0];
    start_fetch(0, 16'd0, 1'b0);
    wait_resp(0, r_ins, r_err, lat);
    chk("postrst0_burst", 64'(bursts[0] - b0), 64'd1);
    chk("postrst0_ins", 64'(r_ins), 64'h100);
    chk("postrst0_miss", 64'(missc[0]), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
